// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned non-restoring divider, one quotient bit per clock.
// Result is packed {remainder, quotient}; divide-by-zero returns {dividend, all-ones}.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] Z
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d, m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sn_q, sn_d, sd_q, sd_d, zero_q, zero_d;
    logic               done_q, done_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, q_fix, r_fix;
    logic [WIDTH:0]     p_sh, p_step, p_fix;

    // Magnitudes are kept unsigned so that -2^(WIDTH-1) stays representable.
    assign dvd_neg = signed_mode & dividend[WIDTH-1];
    assign dvs_neg = signed_mode & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;

    // Add/subtract decision uses the sign of P before the shift; wrap in the
    // shifted value is harmless since the result always lands in [-M, M).
    assign p_sh   = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign p_step = p_q[WIDTH] ? p_sh + {1'b0, m_q} : p_sh - {1'b0, m_q};
    assign p_fix  = p_q[WIDTH] ? p_q + {1'b0, m_q} : p_q;
    assign q_fix  = (sn_q ^ sd_q) ? -q_q : q_q;
    assign r_fix  = sn_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            sn_q    <= 1'b0;
            sd_q    <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            sn_q    <= sn_d;
            sd_q    <= sd_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (divisor == '0) ? FINISH : DIVIDE;
            DIVIDE:  if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p_d    = p_q;
        q_d    = q_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        sn_d   = sn_q;
        sd_d   = sd_q;
        zero_d = zero_q;
        done_d = 1'b0;
        dbz_d  = dbz_q;
        z_d    = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sn_d   = dvd_neg;
                    sd_d   = dvs_neg;
                    zero_d = (divisor == '0);
                    p_d    = '0;
                    cnt_d  = '0;
                    // Zero path carries the raw dividend through Q to the output.
                    q_d    = (divisor == '0) ? dividend : dvd_mag;
                    m_d    = dvs_mag;
                end
            end
            DIVIDE: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + CW'(1);
            end
            FINISH: begin
                done_d = 1'b1;
                if (zero_q) begin
                    z_d   = {q_q, {WIDTH{1'b1}}};
                    dbz_d = 1'b1;
                end else begin
                    z_d   = {r_fix, q_fix};
                    dbz_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        div_by_zero = dbz_q;
        Z           = z_q;
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=32.
module tb_seq_divider;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           clear, start, signed_mode;
    logic [W-1:0]   dividend, divisor;
    logic           busy, done, div_by_zero;
    logic [2*W-1:0] Z;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock(clock), .clear(clear), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .Z(Z)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; issues start, waits for done within a budget,
    // optionally pulses a stray start at cycle `glitch` of the operation.
    task automatic run_div(input string tag, input logic sm, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp_z,
                           input logic exp_dbz, input int exp_lat, input int glitch);
        int cyc;
        start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0; dividend = 'x; divisor = 'x;
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clock); #1;
            start = 1'b0;
            cyc++;
            if (done) break;
            if (cyc == glitch) begin
                start = 1'b1; signed_mode = 1'b0; dividend = 32'd7; divisor = 32'd3;
            end
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_z"}, Z, exp_z);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int ndone;
        clear = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        chk("rst_z", Z, 64'(0));
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); #1;

        run_div("u100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},               1'b0, 33, 0);
        run_div("sm100_7", 1'b1, -32'sd100,      32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2},  1'b0, 33, 0);
        run_div("s100_m7", 1'b1, 32'd100,        -32'sd7,        {32'h00000002, 32'hFFFFFFF2},  1'b0, 33, 0);
        run_div("uffff_2", 1'b0, 32'hFFFFFFFF,   32'd2,          {32'd1, 32'h7FFFFFFF},         1'b0, 33, 0);
        run_div("sm1_2",   1'b1, 32'hFFFFFFFF,   32'd2,          {32'hFFFFFFFF, 32'd0},         1'b0, 33, 0);
        run_div("zero",    1'b0, 32'h12345678,   32'd0,          {32'h12345678, 32'hFFFFFFFF},  1'b1, 1, 0);

        // done is a single-cycle pulse; flag and Z hold afterwards
        @(posedge clock); #1;
        chk("zero_done_pulse", 64'(done), 64'(0));
        chk("zero_dbz_hold", 64'(div_by_zero), 64'(1));
        chk("zero_z_hold", Z, {32'h12345678, 32'hFFFFFFFF});

        run_div("ovf_glitch", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 33, 5);
        run_div("u17_17",     1'b0, 32'd17,       32'd17,       {32'd0, 32'd1},        1'b0, 33, 0);

        // clear mid-division
        start = 1'b1; signed_mode = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 clear = 1'b1;
        #1;
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_done", 64'(done), 64'(0));
        chk("clr_z", Z, 64'(0));
        @(posedge clock); #1;
        clear = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        chk("clr_no_done", 64'(ndone), 64'(0));
        run_div("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised, multi-cycle signed/unsigned integer divider using non-restoring division, one quotient bit per clock. It is the sequential successor of the single-cycle combinational divider in the datapath. It takes operands under a start/done handshake, reports divide-by-zero, and returns `{remainder, quotient}` packed for the HI/LO register pair.

## Interface
Parameters:
- `WIDTH`, 32, operand width in bits; must be 4 or greater.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; captured at start.
- `dividend`  in  WIDTH  numerator; captured at start.
- `divisor`  in  WIDTH  denominator; captured at start.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when Z is valid.
- `div_by_zero`  out  1  set with done when the divisor was 0; held until the next completion.
- `Z`  out  2*WIDTH  `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}`; held until the next completion.

## Operation
- FSM states:
  - IDLE: wait for start.
  - DIVIDE: WIDTH iterations.
  - FINISH: correction, sign fix and output load.
- IDLE, start=1, divisor≠0:
  - Latch the operand signs (signed_mode ? MSB : 0).
  - Latch the magnitudes as WIDTH-bit unsigned values, so a magnitude of 2^(WIDTH-1) is representable.
  - Clear the WIDTH+1-bit partial remainder P and the iteration counter. Go to DIVIDE.
- IDLE, start=1, divisor=0: latch dividend and go straight to FINISH with the zero flag set.
- DIVIDE, each cycle:
  - Shift {P, Q} left by 1.
  - If P is negative, P += M; otherwise P -= M.
  - Q[0] = ~P[WIDTH].
  - After iteration WIDTH-1, go to FINISH.
- FINISH, normal path:
  - If P is negative, P += M (restore).
  - Quotient = Q, negated if the signs differ.
  - Remainder = P[WIDTH-1:0], negated if the dividend is negative. The remainder takes the dividend's sign, and the quotient truncates toward zero.
  - Load Z, clear div_by_zero, pulse done, return to IDLE.
- FINISH, zero path: Z = {dividend, all-ones}, div_by_zero=1, pulse done.
- Overflow: signed -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1) (wraps) and remainder 0. No flag is raised.
- start during DIVIDE or FINISH is ignored; there is no queuing. Operand inputs are don't-care except on the start edge.
- clear at any time:
  - State returns to IDLE.
  - busy=0, done=0, div_by_zero=0, Z=0.
  - Any in-flight result is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, Z=0, state IDLE.
- Start accepted on edge N.
- Normal path:
  - busy=1 after edge N.
  - DIVIDE occupies edges N+1 through N+WIDTH.
  - FINISH executes on edge N+WIDTH+1.
  - After edge N+WIDTH+1: done=1, Z valid, busy=0.
  - Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Zero path:
  - FINISH executes on edge N+1.
  - After edge N+1: done=1, div_by_zero=1, Z valid.
  - Latency is 1 cycle.
- done is high for exactly one cycle.
- Back-to-back: start may be asserted in the cycle done is high. That cycle is IDLE, so the next operation is accepted with no bubble.
- A start sampled while busy=1 never affects the state or outputs.

## Test plan
- WIDTH=32, unsigned 100/7: done exactly 33 cycles after start; Z={32'd2, 32'd14}; div_by_zero=0.
- Signed -100/7: Z={0xFFFFFFFE, 0xFFFFFFF2}. Signed 100/-7: Z={0x00000002, 0xFFFFFFF2}.
- Unsigned 0xFFFFFFFF/2: Z={1, 0x7FFFFFFF}. The same operands with signed_mode=1 (-1/2): Z={0xFFFFFFFF, 0}.
- Divisor 0 with dividend 0x12345678: done 1 cycle after start; Z={0x12345678, 0xFFFFFFFF}; div_by_zero=1. The next valid division clears the flag.
- Signed 0x80000000 / 0xFFFFFFFF: Z={0, 0x80000000}, no flag. Also: a second start pulse at cycle 5 of an operation is ignored, and the result matches the first operands.
- clear at cycle 10 of a division: busy, done and Z go to 0 immediately (asynchronous) and no done follows. A fresh start of 50/5 then returns Z={0, 10} after 33 cycles.
